// File: rtl/alarm_clock_pkg.sv
// Shared key codes, entry-state encoding and HH:MM limits for the alarm clock keypad path.
// Constants and one combinational helper; no latency, no backpressure.
package alarm_clock_pkg;

  localparam logic [3:0] DIGIT_MAX      = 4'd9;
  localparam logic [3:0] ALARM_KEY      = 4'hA;
  localparam logic [3:0] TIME_KEY       = 4'hB;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } entry_state_t;

  // True when the four BCD digits form a legal 24-hour HH:MM.
  function automatic logic bcd_time_valid(
    input logic [3:0] ms_hr,
    input logic [3:0] ls_hr,
    input logic [3:0] ms_min,
    input logic [3:0] ls_min
  );
    logic hr_ok;
    hr_ok = (ms_hr < MAX_MS_HR) || (ms_hr == MAX_MS_HR && ls_hr <= MAX_LS_HR_AT_2);
    return hr_ok && (ms_min <= MAX_MS_MIN) && (ms_hr <= DIGIT_MAX) && (ls_hr <= DIGIT_MAX)
           && (ms_min <= DIGIT_MAX) && (ls_min <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/time_entry_fsm_key_shift_reg.sv
// Four-digit BCD shift register; newest digit enters at the minutes-units end.
// Latency 1 cycle; clear has priority over shift; no backpressure.
module key_shift_reg (
  input  logic       clk,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [3:0] digit,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min
);

  always_ff @(posedge clk) begin
    if (clr) begin
      ms_hr  <= 4'd0;
      ls_hr  <= 4'd0;
      ms_min <= 4'd0;
      ls_min <= 4'd0;
    end else if (shift_en) begin
      ms_hr  <= ls_hr;
      ls_hr  <= ms_min;
      ms_min <= ls_min;
      ls_min <= digit;
    end
  end

endmodule

// File: rtl/time_entry_fsm.sv
// Keypad entry FSM: collects HH:MM digits, validates, and strobes a load into time or alarm.
// All outputs registered, 1-cycle latency from key_valid; inputs are strobes, no backpressure.
module time_entry_fsm
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       entry_error,
  output logic       entry_timeout
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_SEC - 1);

  entry_state_t state;
  logic [3:0]   count;
  logic         is_digit, is_cmd, buf_ok;
  logic         shift_en, clr, timeout_hit;

  always_comb begin
    is_digit    = key_valid && (key <= DIGIT_MAX);
    is_cmd      = key_valid && (key == ALARM_KEY || key == TIME_KEY);
    buf_ok      = bcd_time_valid(new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min);
    shift_en    = is_digit && (state == IDLE || state == ENTRY);
    // A coincident accepted key beats the final tick.
    timeout_hit = (state == ENTRY) && one_second && (count == TO_LAST) && !is_digit && !is_cmd;
    clr         = !reset || (state == COMMIT) || timeout_hit
                  || ((state == ENTRY) && is_cmd && !buf_ok);
  end

  key_shift_reg u_shift (
    .clk      (clk),
    .clr      (clr),
    .shift_en (shift_en),
    .digit    (key),
    .ms_hr    (new_time_ms_hr),
    .ls_hr    (new_time_ls_hr),
    .ms_min   (new_time_ms_min),
    .ls_min   (new_time_ls_min)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 4'd0;
      load_new_c    <= 1'b0;
      load_new_a    <= 1'b0;
      show_new_time <= 1'b0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      load_new_c    <= 1'b0;
      load_new_a    <= 1'b0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
      case (state)
        IDLE: begin
          count <= 4'd0;
          if (is_digit) begin
            state         <= ENTRY;
            show_new_time <= 1'b1;
          end else begin
            show_new_time <= 1'b0;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            count <= 4'd0;
          end else if (is_cmd) begin
            count <= 4'd0;
            if (buf_ok) begin
              state      <= COMMIT;
              load_new_c <= (key == TIME_KEY);
              load_new_a <= (key == ALARM_KEY);
            end else begin
              state         <= IDLE;
              show_new_time <= 1'b0;
              entry_error   <= 1'b1;
            end
          end else if (timeout_hit) begin
            state         <= IDLE;
            count         <= 4'd0;
            show_new_time <= 1'b0;
            entry_timeout <= 1'b1;
          end else if (one_second) begin
            count <= count + 4'd1;
          end
        end
        COMMIT: begin
          state         <= IDLE;
          count         <= 4'd0;
          show_new_time <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          count         <= 4'd0;
          show_new_time <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/time_entry_fsm.md
Name: time_entry_fsm

Overview:
- Keypad-side writer for the clock's loadable time counter and alarm register.
- Collects debounced key presses into a 4-digit BCD buffer and checks it as a valid HH:MM.
- Issues a one-cycle load strobe with stable digits to the time counter (load_new_c) or the alarm register (load_new_a).
- Abandons an entry after a configurable inactivity timeout.

Parameters:
- TIMEOUT_SEC, 10, whole one_second ticks of inactivity in ENTRY before the entry is abandoned (legal range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- one_second  input  1  single-cycle tick, once per second
- key_valid  input  1  single-cycle strobe, one per debounced key press
- key  input  4  key code, qualified by key_valid
- new_time_ms_hr  output  4  buffer digit, tens of hours
- new_time_ls_hr  output  4  buffer digit, units of hours
- new_time_ms_min  output  4  buffer digit, tens of minutes
- new_time_ls_min  output  4  buffer digit, units of minutes
- load_new_c  output  1  one-cycle strobe: load the buffer into the time counter
- load_new_a  output  1  one-cycle strobe: load the buffer into the alarm register
- show_new_time  output  1  display mux select, 1 = show the buffer
- entry_error  output  1  one-cycle strobe: rejected commit
- entry_timeout  output  1  one-cycle strobe: entry abandoned

Behaviour:
- Key codes:
  - 0..9 = DIGIT
  - 4'hA = ALARM_KEY
  - 4'hB = TIME_KEY
  - 4'hC..4'hF = ignored, and they do not restart the timeout
- All outputs are registered.
- Reset (reset==0 at a clk edge):
  - state = IDLE
  - all buffer digits = 0
  - timeout count = 0
  - every strobe = 0
  - show_new_time = 0
  - Reset wins over every other input and aborts an entry or commit in progress.
- States: IDLE, ENTRY, COMMIT.
- IDLE:
  - DIGIT: shift it in and go to ENTRY.
  - TIME_KEY and ALARM_KEY: ignored. Nothing is committed from an empty buffer.
  - show_new_time = 0.
- Shift on an accepted DIGIT d:
  - ms_hr <= ls_hr, ls_hr <= ms_min, ms_min <= ls_min, ls_min <= d.
  - The new digits are visible on the outputs the cycle after the key_valid cycle.
  - More than 4 digits keep shifting; the oldest digit is lost.
  - Fewer than 4 digits give leading zeros ("5" = 00:05).
- ENTRY (show_new_time = 1):
  - DIGIT: shift, clear the timeout count.
  - TIME_KEY or ALARM_KEY with a valid buffer: go to COMMIT. In the next cycle exactly one of load_new_c (TIME_KEY) or load_new_a (ALARM_KEY) is 1 for one cycle.
  - TIME_KEY or ALARM_KEY with an invalid buffer: entry_error = 1 for one cycle, then go to IDLE and clear the buffer.
- Valid buffer rule:
  - (ms_hr < 2, or ms_hr == 2 and ls_hr <= 3)
  - and ms_min <= 5
  - and every digit <= 9 (always true for DIGIT input).
  - Examples: 23:59 valid; 24:00, 19:60 and 29:00 invalid.
- COMMIT:
  - Lasts exactly one cycle.
  - The load strobe is high and the buffer outputs hold the committed digits during this cycle.
  - Next cycle: IDLE, buffer cleared to 0000, strobe low.
  - key_valid during COMMIT is ignored, even a DIGIT.
- Timeout:
  - A 4-bit counter increments on one_second while in ENTRY.
  - If one_second arrives while count == TIMEOUT_SEC-1 and no accepted key arrives in the same cycle: go to IDLE, clear the buffer and count, entry_timeout = 1 for one cycle.
  - Simultaneous accepted key and one_second: the key wins and the count is cleared.
  - Count is held at 0 outside ENTRY.
- Strobes are mutually exclusive and never high for 2 cycles in a row.

Decomposition:
- Shared package alarm_clock_pkg:
  - key code constants DIGIT_MAX=9, ALARM_KEY=4'hA, TIME_KEY=4'hB
  - entry state enum {IDLE, ENTRY, COMMIT}
  - BCD limit constants MAX_MS_HR=2, MAX_LS_HR_AT_2=3, MAX_MS_MIN=5
- One sub-module, key_shift_reg:
  - 4-digit BCD shift register
  - inputs: shift enable, clear, digit
  - exposes the four digits
  - The FSM, validation and timeout stay in time_entry_fsm.

Test Plan:
- reset=0 for 2 cycles mid-ENTRY with buffer 12:34 -> next cycle all digits 0, all strobes 0, show_new_time=0, state IDLE.
- Keys 2,3,5,9 then TIME_KEY -> one cycle later load_new_c=1 for exactly one cycle with digits 2,3,5,9; load_new_a=0; next cycle digits 0000, show_new_time=0.
- Keys 0,7,3,0 then ALARM_KEY -> load_new_a=1 for one cycle with 07:30; load_new_c stays 0.
- Keys 2,4,0,0 then TIME_KEY -> entry_error=1 for one cycle, no load strobe, buffer 0000. Repeat with 1,9,6,0 -> same result.
- Keys 1,2,3,4,5 then TIME_KEY -> load_new_c with digits 2,3,4,5. Key 5 alone then TIME_KEY -> load with 0,0,0,5.
- TIMEOUT_SEC=10:
  - key 1, then 9 one_second ticks, then key 2 coinciding with the 10th tick -> still in ENTRY with buffer 00:12.
  - 10 further ticks with no key -> entry_timeout=1 for one cycle, IDLE, buffer 0000.
  - TIME_KEY in IDLE -> no strobe.
